// File: rtl/gate_ref_pkg.sv
// Shared definitions for the registered golden-reference gate model:
// function codes, input width and the active-input-count rule.
package gate_ref_pkg;

    localparam int N_MAX = 8;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NAND = 3'd2,
        GATE_NOR  = 3'd3,
        GATE_XOR  = 3'd4,
        GATE_XNOR = 3'd5
    } gate_sel_t;

    // An input count of 0 or anything above N_MAX means "all inputs active".
    function automatic logic [3:0] eff_inputs(input logic [3:0] n);
        return (n == 4'd0 || n > 4'(N_MAX)) ? 4'(N_MAX) : n;
    endfunction

endpackage

// File: rtl/gate_reduce8.sv
// Combinational masking plus the six reductions of the low n_inputs bits.
// Inactive bits are replaced by the identity element of each reduction.
module gate_reduce8
    import gate_ref_pkg::*;
(
    input  logic [N_MAX-1:0] in_pattern,
    input  logic [3:0]       n_inputs,
    output logic             and_r,
    output logic             or_r,
    output logic             nand_r,
    output logic             nor_r,
    output logic             xor_r,
    output logic             xnor_r
);

    logic [3:0]       n_eff;
    logic [N_MAX-1:0] and_in;
    logic [N_MAX-1:0] or_in;

    assign n_eff = eff_inputs(n_inputs);

    always_comb begin
        // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
        and_in = '1;
        or_in  = '0;
        for (int i = 0; i < N_MAX; i++) begin
            if (4'(i) < n_eff) begin
                and_in[i] = in_pattern[i];
                or_in[i]  = in_pattern[i];
            end
        end
    end

    // OR, NOR, XOR and XNOR share the zero-filled vector.
    assign and_r  = &and_in;
    assign nand_r = ~and_r;
    assign or_r   = |or_in;
    assign nor_r  = ~or_r;
    assign xor_r  = ^or_in;
    assign xnor_r = ~xor_r;

endmodule

// File: rtl/nand8_gate_ref.sv
// Registered golden-reference gate: masked reduction, function select and a
// one-cycle output stage, plus the legacy combinational 8-input NAND tap.
module nand8_gate_ref
    import gate_ref_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_MAX-1:0] in_pattern,
    input  logic [3:0]       n_inputs,
    input  logic [2:0]       gateSelect,
    output logic             y,
    output logic             y_valid,
    output logic             sel_err,
    output logic             nand8
);

    logic and_r, or_r, nand_r, nor_r, xor_r, xnor_r;
    logic result;
    logic illegal;

    gate_reduce8 u_reduce (
        .in_pattern (in_pattern),
        .n_inputs   (n_inputs),
        .and_r      (and_r),
        .or_r       (or_r),
        .nand_r     (nand_r),
        .nor_r      (nor_r),
        .xor_r      (xor_r),
        .xnor_r     (xnor_r)
    );

    always_comb begin
        result  = 1'b0;
        illegal = 1'b0;
        case (gate_sel_t'(gateSelect))
            GATE_AND:  result = and_r;
            GATE_OR:   result = or_r;
            GATE_NAND: result = nand_r;
            GATE_NOR:  result = nor_r;
            GATE_XOR:  result = xor_r;
            GATE_XNOR: result = xnor_r;
            default:   illegal = 1'b1;
        endcase
    end

    // Reset wins over a same-cycle sample; y and sel_err hold while idle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            y       <= 1'b0;
            sel_err <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= in_valid;
            if (in_valid) begin
                y       <= result;
                sel_err <= illegal;
            end
        end
    end

    assign nand8 = ~&in_pattern;

endmodule

// File: tb/tb_nand8_gate_ref.sv
// Scoreboard bench: the driver pushes model predictions, a monitor pops and
// compares them whenever the DUT reports y_valid.
module tb_nand8_gate_ref;

    typedef struct packed {
        logic y;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_pattern = 8'h00;
    logic [3:0] n_inputs = 4'd8;
    logic [2:0] gateSelect = 3'd2;
    logic       y, y_valid, sel_err, nand8;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_y = 1'b0;
    logic exp_err = 1'b0;

    nand8_gate_ref dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pattern (in_pattern),
        .n_inputs   (n_inputs),
        .gateSelect (gateSelect),
        .y          (y),
        .y_valid    (y_valid),
        .sel_err    (sel_err),
        .nand8      (nand8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Reference: count the ones among the active inputs and decide from that.
    function automatic exp_t model(input logic [7:0] p, input logic [3:0] n,
                                   input logic [2:0] s);
        int   na;
        int   ones;
        logic all1, any1, odd;
        exp_t r;
        na   = (n == 0 || n > 8) ? 8 : int'(n);
        ones = 0;
        for (int i = 0; i < na; i++) ones += int'(p[i]);
        all1 = (ones == na);
        any1 = (ones > 0);
        odd  = (ones % 2 == 1);
        r.err = 1'b0;
        case (s)
            3'd0: r.y = all1;
            3'd1: r.y = any1;
            3'd2: r.y = !all1;
            3'd3: r.y = !any1;
            3'd4: r.y = odd;
            3'd5: r.y = !odd;
            default: begin
                r.y   = 1'b0;
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic apply(input logic r, input logic v, input logic [7:0] p,
                         input logic [3:0] n, input logic [2:0] s);
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        in_pattern = p;
        n_inputs   = n;
        gateSelect = s;
        if (v && !r) q.push_back(model(p, n, s));
    endtask

    // Monitor: one look per cycle, just after the active edge.
    always begin
        exp_t item;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_y   = 1'b0;
            exp_err = 1'b0;
        end
        check("y_valid", y_valid, q.size() > 0);
        if (y_valid && q.size() > 0) begin
            item    = q.pop_front();
            exp_y   = item.y;
            exp_err = item.err;
        end
        check("y", y, exp_y);
        check("sel_err", sel_err, exp_err);
        check("nand8", nand8, ~&in_pattern);
    end

    initial begin
        // Reset with a colliding sample.
        apply(1'b1, 1'b1, 8'h00, 4'd8, 3'd2);
        apply(1'b1, 1'b1, 8'h00, 4'd8, 3'd2);

        // Exhaustive 8-input NAND, back-to-back.
        for (int i = 0; i < 256; i++) apply(1'b0, 1'b1, 8'(i), 4'd8, 3'd2);

        // Masking with two active inputs.
        apply(1'b0, 1'b1, 8'b1111_1101, 4'd2, 3'd0);
        apply(1'b0, 1'b1, 8'b1111_1101, 4'd2, 3'd1);
        apply(1'b0, 1'b1, 8'b1111_1101, 4'd2, 3'd4);
        apply(1'b0, 1'b1, 8'b1111_1101, 4'd2, 3'd5);

        // All functions on 8'h07.
        for (int s = 0; s < 6; s++) apply(1'b0, 1'b1, 8'h07, 4'd8, 3'(s));

        // Illegal select then recovery.
        apply(1'b0, 1'b1, 8'($urandom), 4'd8, 3'd6);
        apply(1'b0, 1'b1, 8'h00, 4'd8, 3'd3);

        // Hold for five idle cycles.
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 8'($urandom), 4'($urandom), 3'($urandom));

        // Sticky state then reset colliding with a sample; n_inputs 0 and 15 boundaries.
        apply(1'b0, 1'b1, 8'hFF, 4'd0, 3'd7);
        apply(1'b1, 1'b1, 8'hFF, 4'd8, 3'd0);
        apply(1'b0, 1'b1, 8'hFF, 4'd0, 3'd2);
        apply(1'b0, 1'b1, 8'h7F, 4'd15, 3'd0);
        apply(1'b0, 1'b1, 8'h7F, 4'd7, 3'd0);
        apply(1'b0, 1'b1, 8'h01, 4'd1, 3'd5);

        // Randomised traffic with occasional resets and idles.
        for (int i = 0; i < 400; i++)
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 4'($urandom), 3'($urandom));

        apply(1'b0, 1'b0, 8'h00, 4'd8, 3'd2);
        apply(1'b0, 1'b0, 8'h00, 4'd8, 3'd2);
        @(negedge clk);
        check("drained", q.size() == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
